// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, handshakes with instruction
// memory, buffers one word across decode stalls and squashes/refetches on
// jump/branch redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_next,
    output logic [31:0] pc_out,
    output logic        valid
);

    // REQ   | request outstanding at req_addr
    // HOLD  | fetched word parked in buffer while decode stalls
    // DRAIN | outstanding request abandoned; its word is dropped on arrival
    typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] req_addr, req_addr_nx;
    logic [31:0] buf_data, buf_data_nx;
    logic [31:0] buf_addr, buf_addr_nx;
    logic [31:0] ins_nx, pc_out_nx, pc_next_nx;
    logic        valid_nx;
    logic [31:0] target;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    // Request outputs depend on registered state only.
    assign imem_req  = (state != HOLD);
    assign imem_addr = req_addr;

    // Next-state, address and output-register decode.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        buf_data_nx = buf_data;
        buf_addr_nx = buf_addr;
        ins_nx      = instruction;
        pc_out_nx   = pc_out;
        pc_next_nx  = pc_next;
        valid_nx    = valid;

        if (redirect) begin
            // Squash whatever decode would see next.
            ins_nx   = 32'h0;
            valid_nx = 1'b0;
        end

        case (state)
            REQ: begin
                if (redirect) begin
                    if (imem_ready) begin
                        req_addr_nx = target;
                    end else begin
                        pc_nx    = target;
                        state_nx = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (we) begin
                        ins_nx      = imem_rdata;
                        pc_out_nx   = req_addr;
                        pc_next_nx  = req_addr + 32'd4;
                        valid_nx    = 1'b1;
                        req_addr_nx = req_addr + 32'd4;
                    end else begin
                        buf_data_nx = imem_rdata;
                        buf_addr_nx = req_addr;
                        state_nx    = HOLD;
                    end
                end else if (we) begin
                    ins_nx   = 32'h0;
                    valid_nx = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    req_addr_nx = target;
                    state_nx    = REQ;
                end else if (we) begin
                    ins_nx      = buf_data;
                    pc_out_nx   = buf_addr;
                    pc_next_nx  = buf_addr + 32'd4;
                    valid_nx    = 1'b1;
                    req_addr_nx = buf_addr + 32'd4;
                    state_nx    = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    // Newest target wins; if the stale word lands now, go straight there.
                    if (imem_ready) begin
                        req_addr_nx = target;
                        state_nx    = REQ;
                    end else begin
                        pc_nx = target;
                    end
                end else begin
                    if (we) begin
                        ins_nx   = 32'h0;
                        valid_nx = 1'b0;
                    end
                    if (imem_ready) begin
                        req_addr_nx = pc;
                        state_nx    = REQ;
                    end
                end
            end
            default: state_nx = REQ;
        endcase
    end

    // State, address, buffer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            buf_data    <= 32'h0;
            buf_addr    <= 32'h0;
            instruction <= 32'h0;
            pc_out      <= 32'h0;
            pc_next     <= 32'h0;
            valid       <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            req_addr    <= req_addr_nx;
            buf_data    <= buf_data_nx;
            buf_addr    <= buf_addr_nx;
            instruction <= ins_nx;
            pc_out      <= pc_out_nx;
            pc_next     <= pc_next_nx;
            valid       <= valid_nx;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, checked
// every cycle against a transaction-level model of the fetch stream.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction, pc_next, pc_out;
    logic        valid;

    int errors = 0;
    int checks = 0;

    // Model of the fetch stream
    logic [31:0] m_fetch;      // address being requested from memory
    logic        m_drop;       // current request is wrong-path, discard its word
    logic [31:0] m_target;     // where to fetch once the dropped word arrives
    logic        m_held;       // a fetched word is waiting for decode
    logic [31:0] m_held_addr;
    logic [31:0] m_ins, m_pc, m_pcn;
    logic        m_val;
    int          mem_cnt;
    int          wait_n;       // fixed wait states; negative = random ready

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .we(we), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc_next(pc_next), .pc_out(pc_out),
        .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a + 32'h1000_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = RST_PC; m_drop = 1'b0; m_target = 32'h0;
        m_held = 1'b0; m_held_addr = 32'h0;
        m_ins = 32'h0; m_pc = 32'h0; m_pcn = 32'h0; m_val = 1'b0;
        mem_cnt = 0;
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic [31:0] rt);
        logic        req, rdy, got;
        logic [31:0] t;
        @(negedge clk);
        req = !m_held;
        if (wait_n < 0) rdy = req && ($urandom_range(0, 1) == 1);
        else            rdy = req && (mem_cnt >= wait_n);
        reset = r; we = w; redirect = rd; redirect_pc = rt;
        imem_ready = rdy; imem_rdata = word_of(m_fetch);
        @(posedge clk);
        t   = {rt[31:2], 2'b00};
        got = req && rdy;
        if (got || !req) mem_cnt = 0; else mem_cnt++;
        if (r) begin
            model_reset();
        end else if (rd) begin
            m_ins = 32'h0; m_val = 1'b0;
            if (m_held) begin
                m_held = 1'b0; m_fetch = t; m_drop = 1'b0; mem_cnt = 0;
            end else if (got) begin
                m_fetch = t; m_drop = 1'b0;
            end else begin
                m_drop = 1'b1; m_target = t;
            end
        end else if (m_held) begin
            if (w) begin
                m_ins = word_of(m_held_addr); m_pc = m_held_addr;
                m_pcn = m_held_addr + 32'd4; m_val = 1'b1;
                m_held = 1'b0; m_fetch = m_held_addr + 32'd4;
            end
        end else if (got) begin
            if (m_drop) begin
                m_drop = 1'b0; m_fetch = m_target;
                if (w) begin m_ins = 32'h0; m_val = 1'b0; end
            end else if (w) begin
                m_ins = word_of(m_fetch); m_pc = m_fetch;
                m_pcn = m_fetch + 32'd4; m_val = 1'b1;
                m_fetch = m_fetch + 32'd4;
            end else begin
                m_held = 1'b1; m_held_addr = m_fetch;
            end
        end else if (w) begin
            m_ins = 32'h0; m_val = 1'b0;
        end
        #1;
        chk("instruction", instruction, m_ins);
        chk("pc_out", pc_out, m_pc);
        chk("pc_next", pc_next, m_pcn);
        chk("valid", {31'h0, valid}, {31'h0, m_val});
        chk("imem_req", {31'h0, imem_req}, {31'h0, !m_held});
        if (!m_held) chk("imem_addr", imem_addr, m_fetch);
    endtask

    initial begin
        model_reset();
        wait_n = 0;
        // reset
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        // zero-wait streaming from RESET_PC
        repeat (4) step(0, 1, 0, 0);
        // two wait states
        wait_n = 2;
        repeat (7) step(0, 1, 0, 0);
        // stall for three cycles then release
        wait_n = 0;
        repeat (3) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        // redirect while slow request outstanding
        wait_n = 2;
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h0000_0400);
        repeat (8) step(0, 1, 0, 0);
        // redirect while word is held, unaligned target
        wait_n = 0;
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0403);
        repeat (3) step(0, 1, 0, 0);
        // redirect coincident with a returning word
        step(0, 1, 1, 32'h0000_0800);
        repeat (2) step(0, 1, 0, 0);
        // redirect during drain, then another one
        wait_n = 3;
        step(0, 1, 1, 32'h0000_0A00);
        step(0, 1, 1, 32'h0000_0B00);
        repeat (8) step(0, 1, 0, 0);
        // reset in the middle of a wait
        wait_n = 2;
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        // address wrap
        wait_n = 0;
        step(0, 1, 1, 32'hFFFF_FFFC);
        repeat (3) step(0, 1, 0, 0);
        // random traffic
        wait_n = -1;
        for (int i = 0; i < 800; i++) begin
            logic        r, w, rd;
            logic [31:0] rt;
            r  = ($urandom_range(0, 99) == 0);
            w  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 11) == 0);
            rt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + ($urandom & 32'h7)
                                              : ($urandom & 32'h0000_3FFF);
            step(r, w, rd, rt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the program counter, runs a request/ready handshake with instruction memory, and presents each fetched word with its PC+4 to decode through an output register. It also absorbs decode stalls with a one-entry holding buffer and handles jump/branch redirects from later stages, discarding any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- we  in  1  pipeline advance enable from hazard unit; 0 = decode stalled, IF outputs hold
- redirect  in  1  one-cycle pulse: taken jump/branch, refetch from redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00)
- imem_req  out  1  fetch request; held high until imem_ready
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and not ready
- imem_ready  in  1  memory has imem_rdata valid this cycle (sampled only when imem_req=1)
- imem_rdata  in  32  fetched instruction word
- instruction  out  32  registered instruction to decode; 0 (NOP) for bubble
- pc_next  out  32  registered PC+4 of instruction
- pc_out  out  32  registered PC of instruction (EPC source)
- valid  out  1  registered: instruction is a real fetch, not a bubble

## Operation
- Registers: pc (next fetch address), req_addr (address of outstanding request), buf_data/buf_addr (holding buffer), state, output registers.
- States: REQ (request outstanding), HOLD (word buffered, decode stalled), DRAIN (outstanding request must be discarded).
- REQ: imem_req=1, imem_addr=req_addr.
  - imem_ready & we: outputs <= {imem_rdata, req_addr, req_addr+4, valid=1}; req_addr <= req_addr+4; stay REQ.
  - imem_ready & !we: buf <= {imem_rdata, req_addr}; outputs hold; -> HOLD.
  - !imem_ready & we: outputs <= bubble (instruction=0, valid=0, pc_out/pc_next unchanged).
- HOLD: imem_req=0. When we: outputs <= buffered word (valid=1); req_addr <= buf_addr+4; -> REQ. Otherwise hold.
- DRAIN: imem_req=1, imem_addr=req_addr (the abandoned address, held stable per protocol). On imem_ready: drop word; req_addr <= pc; -> REQ. Outputs load bubble when we=1.
- redirect (priority over all of the above except reset):
  - outputs <= bubble regardless of we (squash wrong-path instruction).
  - REQ with !imem_ready: -> DRAIN; pc <= {redirect_pc[31:2],2'b00}.
  - REQ with imem_ready, or HOLD: returned/buffered word dropped; req_addr <= {redirect_pc[31:2],2'b00}; -> REQ.
  - DRAIN: pc overwritten with new target; stay DRAIN (latest redirect wins).
- PC arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- reset: state=REQ; req_addr=pc=RESET_PC; buffer cleared; instruction=0, pc_next=0, pc_out=0, valid=0. An outstanding request at reset is abandoned; memory is assumed reset by the same signal.

## Timing
- imem_req and imem_addr are decodes of registered state only (no combinational path from imem_ready).
- Zero-wait memory (ready in the request cycle): one instruction per cycle; word fetched at cycle N appears on outputs after edge N.
- Wait states: each extra memory cycle inserts one bubble when we=1.
- First request: cycle after reset deassertion sees imem_addr=RESET_PC.
- Redirect at edge N: wrong-path output squashed at edge N; with zero-wait memory target instruction valid at outputs after edge N+1 (one bubble).
- Stall: outputs frozen for every cycle we=0 (except redirect squash); no instruction lost or duplicated.

## Test plan
- Reset RESET_PC=32'h100, zero-wait memory returning word=addr: outputs after successive edges show pc_out 0x100,0x104,0x108, pc_next=pc_out+4, valid=1.
- Memory with 2 wait states: imem_addr stable for 3 cycles per fetch, valid=1 one cycle in three, bubbles have instruction=0.
- we=0 for 3 cycles arriving with word at 0x108: HOLD entered, imem_req=0, outputs hold 0x104; on we=1, 0x108 output then fetch 0x10C; no skip/duplicate.
- redirect to 0x400 while 2-wait request to 0x10C outstanding: DRAIN, 0x10C word discarded, next request 0x400, next valid pc_out=0x400.
- redirect in HOLD and simultaneous redirect+imem_ready: buffered/returned word dropped, bubble output, next fetch at target; redirect_pc=0x403 fetches 0x400.
- Reset asserted mid-wait and PC 0xFFFF_FFFC fetch: all outputs zero, restart at RESET_PC; wrap case gives pc_next=0 then fetch address 0.
